// File: rtl/lambda_peak_detect_if.sv
// Lambda sample stream in, per-window peak result out, plus the window restart pulse.
// master drives samples and consumes results; slave is the peak detector.
interface lambda_peak_detect_if #(
   parameter int WIN_LEN  = 80,
   parameter int LAMBDA_W = 14
);
   localparam int IDX_W = $clog2(WIN_LEN);

   logic                       clr;
   logic                       in_valid;
   logic                       in_ready;
   logic signed [LAMBDA_W-1:0] lambda_in;
   logic                       out_valid;
   logic                       out_ready;
   logic        [IDX_W-1:0]    theta_out;
   logic signed [LAMBDA_W-1:0] peak_out;

   modport master (
      output clr, in_valid, lambda_in, out_ready,
      input  in_ready, out_valid, theta_out, peak_out
   );

   modport slave (
      input  clr, in_valid, lambda_in, out_ready,
      output in_ready, out_valid, theta_out, peak_out
   );
endinterface

// File: rtl/lambda_peak_detect.sv
// Finds the first-occurring maximum of lambda over each WIN_LEN-sample window; result is registered
// one cycle after the closing sample and held until taken; only the closing sample stalls on a held result.
module lambda_peak_detect #(
   parameter int WIN_LEN  = 80,
   parameter int LAMBDA_W = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   lambda_peak_detect_if.slave  bus
);
   localparam int               IDX_W    = $clog2(WIN_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

   logic        [IDX_W-1:0]    r_idx;
   logic        [IDX_W-1:0]    r_cur_arg;
   logic signed [LAMBDA_W-1:0] r_cur_max;
   logic                       r_out_valid;
   logic        [IDX_W-1:0]    r_theta;
   logic signed [LAMBDA_W-1:0] r_peak;

   logic                       w_last;
   logic                       w_accept;
   logic                       w_first;
   logic                       w_gt;
   logic                       w_close;
   logic signed [LAMBDA_W-1:0] w_next_max;
   logic        [IDX_W-1:0]    w_next_arg;

   assign w_last       = (r_idx == LAST_IDX);
   // Depends only on state and out_ready, never on the incoming sample.
   assign bus.in_ready = !(r_out_valid && !bus.out_ready && w_last);
   assign w_accept     = bus.in_valid && bus.in_ready;
   // A sample arriving with clr opens the new window, so it is treated like index 0.
   assign w_first      = bus.clr || (r_idx == '0);
   assign w_gt         = (bus.lambda_in > r_cur_max);
   assign w_close      = w_accept && w_last && !bus.clr;

   always_comb begin
      w_next_max = r_cur_max;
      w_next_arg = r_cur_arg;
      if (w_first) begin
         w_next_max = bus.lambda_in;
         w_next_arg = '0;
      end else if (w_gt) begin
         w_next_max = bus.lambda_in;
         w_next_arg = r_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= '0;
         r_cur_arg   <= '0;
         r_cur_max   <= '0;
         r_out_valid <= 1'b0;
         r_theta     <= '0;
         r_peak      <= '0;
      end else begin
         if (bus.clr) begin
            r_idx <= w_accept ? IDX_W'(1) : '0;
         end else if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
         end

         if (w_accept) begin
            r_cur_max <= w_next_max;
            r_cur_arg <= w_next_arg;
         end else if (bus.clr) begin
            r_cur_max <= '0;
            r_cur_arg <= '0;
         end

         // A close in the same cycle as a handshake reloads rather than clears.
         if (w_close) begin
            r_out_valid <= 1'b1;
            r_theta     <= w_next_arg;
            r_peak      <= w_next_max;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.theta_out = r_theta;
   assign bus.peak_out  = r_peak;
endmodule

// File: tb/tb_lambda_peak_detect.sv
// Directed and short randomized checks of lambda_peak_detect with WIN_LEN=80, LAMBDA_W=14.
module tb_lambda_peak_detect;
   localparam int WIN_LEN  = 80;
   localparam int LAMBDA_W = 14;

   logic clk;
   logic rst;

   lambda_peak_detect_if #(.WIN_LEN(WIN_LEN), .LAMBDA_W(LAMBDA_W)) bus ();

   lambda_peak_detect #(.WIN_LEN(WIN_LEN), .LAMBDA_W(LAMBDA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int last_stalls = 0;
   int stall_sum;
   int obs_theta[$];
   int obs_peak[$];
   int exp_theta[$];
   int exp_peak[$];
   int win_q[$];
   int v, cyc, bm, ba;
   bit m_pend, e_rdy, acc, hs, close_c;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offer one sample (optionally with clr) until accepted; returns just after the accepting edge.
   task automatic send(input int val, input bit c);
      int n;
      n = 0;
      bus.in_valid  = 1'b1;
      bus.lambda_in = LAMBDA_W'(val);
      bus.clr       = c;
      #1;
      while (!bus.in_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) chk("send_stall", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clr      = 1'b0;
      last_stalls  = n;
   endtask

   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         obs_theta.push_back(int'(bus.theta_out));
         obs_peak.push_back(int'(bus.peak_out));
      end
   end

   initial begin
      rst           = 1'b1;
      bus.clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.lambda_in = '0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_theta", bus.theta_out, 0);
      chk("rst_peak", bus.peak_out, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;

      // Ramp -40..39: peak at the last index.
      for (int i = 0; i < WIN_LEN; i++) begin
         send(i - 40, 1'b0);
         if (i == WIN_LEN - 2) chk("ramp_not_early", bus.out_valid, 0);
      end
      chk("ramp_valid", bus.out_valid, 1);
      chk("ramp_theta", bus.theta_out, 79);
      chk("ramp_peak", bus.peak_out, 39);

      // Ties keep the earliest index.
      for (int i = 0; i < WIN_LEN; i++) begin
         send((i == 12 || i == 60) ? 5 : -100, 1'b0);
         if (i == 0) chk("ties_no_gap", last_stalls, 0);
      end
      chk("ties_valid", bus.out_valid, 1);
      chk("ties_theta", bus.theta_out, 12);
      chk("ties_peak", bus.peak_out, 5);

      for (int i = 0; i < WIN_LEN; i++) send(-8192, 1'b0);
      chk("min_valid", bus.out_valid, 1);
      chk("min_theta", bus.theta_out, 0);
      chk("min_peak", bus.peak_out, -8192);

      // Backpressure: hold result A while window B fills, stall only its closing sample.
      for (int i = 0; i < WIN_LEN; i++) send(79 - i, 1'b0);
      chk("bp1_valid", bus.out_valid, 1);
      chk("bp1_theta", bus.theta_out, 0);
      chk("bp1_peak", bus.peak_out, 79);
      bus.out_ready = 1'b0;
      stall_sum = 0;
      for (int i = 0; i < WIN_LEN - 1; i++) begin
         send((i == 50) ? 300 : -i, 1'b0);
         stall_sum += last_stalls;
      end
      chk("bp_no_stall", stall_sum, 0);
      bus.in_valid  = 1'b1;
      bus.lambda_in = LAMBDA_W'(-1);
      #1;
      chk("bp_in_ready_low", bus.in_ready, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_theta", bus.theta_out, 0);
      chk("bp_hold_peak", bus.peak_out, 79);
      chk("bp_hold_in_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp2_valid", bus.out_valid, 1);
      chk("bp2_theta", bus.theta_out, 50);
      chk("bp2_peak", bus.peak_out, 300);

      // clr with the sample at index 30 discards the earlier 900.
      for (int i = 0; i < 30; i++) send((i == 5) ? 900 : 0, 1'b0);
      send(500, 1'b1);
      for (int k = 1; k < WIN_LEN; k++) begin
         send(k, 1'b0);
         if (k == WIN_LEN - 2) chk("clr_not_early", bus.out_valid, 0);
      end
      chk("clr_valid", bus.out_valid, 1);
      chk("clr_theta", bus.theta_out, 0);
      chk("clr_peak", bus.peak_out, 500);

      // clr on what would be the closing sample suppresses the result.
      for (int i = 0; i < WIN_LEN - 1; i++) send(i, 1'b0);
      send(1000, 1'b1);
      chk("clrclose_no_result", bus.out_valid, 0);
      for (int k = 1; k < WIN_LEN; k++) send(-5, 1'b0);
      chk("clrclose_valid", bus.out_valid, 1);
      chk("clrclose_theta", bus.theta_out, 0);
      chk("clrclose_peak", bus.peak_out, 1000);

      // Reset with a pending result and a half-filled window.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 40; i++) send(2000, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst2_out_valid", bus.out_valid, 0);
      chk("rst2_theta", bus.theta_out, 0);
      chk("rst2_peak", bus.peak_out, 0);
      chk("rst2_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < WIN_LEN; i++) begin
         send((i == 33) ? 7 : i - 100, 1'b0);
         if (i == WIN_LEN - 2) chk("rst2_not_early", bus.out_valid, 0);
      end
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_theta", bus.theta_out, 33);
      chk("post_rst_peak", bus.peak_out, 7);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rnd_out_valid", bus.out_valid, 0);
      obs_theta.delete();
      obs_peak.delete();

      // Random traffic against a window-buffer reference model.
      m_pend = 1'b0;
      cyc    = 0;
      while (exp_theta.size() < 30 && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("rnd_out_valid", bus.out_valid, m_pend);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.clr       = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 15)) - 8;
         else                           v = int'($urandom_range(0, 16383)) - 8192;
         bus.lambda_in = LAMBDA_W'(v);
         #1;
         e_rdy = !(m_pend && !bus.out_ready && win_q.size() == WIN_LEN - 1);
         chk("rnd_in_ready", bus.in_ready, e_rdy);
         acc     = bus.in_valid && e_rdy;
         hs      = m_pend && bus.out_ready;
         close_c = 1'b0;
         if (bus.clr) begin
            win_q.delete();
            if (acc) win_q.push_back(v);
         end else if (acc) begin
            win_q.push_back(v);
            if (win_q.size() == WIN_LEN) begin
               bm = win_q[0];
               ba = 0;
               for (int j = 1; j < WIN_LEN; j++) begin
                  if (win_q[j] > bm) begin
                     bm = win_q[j];
                     ba = j;
                  end
               end
               exp_theta.push_back(ba);
               exp_peak.push_back(bm);
               win_q.delete();
               close_c = 1'b1;
            end
         end
         if (close_c)  m_pend = 1'b1;
         else if (hs)  m_pend = 1'b0;
      end
      if (cyc >= 20000) chk("rnd_timeout", exp_theta.size(), 30);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.clr       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rnd_count", obs_theta.size(), exp_theta.size());
      for (int k = 0; k < exp_theta.size() && k < obs_theta.size(); k++) begin
         chk("rnd_theta", obs_theta[k], exp_theta[k]);
         chk("rnd_peak", obs_peak[k], exp_peak[k]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
